// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the PC alignment helper.
package fetch_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instructions are word aligned, so the two low address bits are dropped.
  function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Count up on inc, stop once every bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: picks redirect / BTB target / PC+4 and fills IF/ID.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             btb_valid,
  input  logic             btb_taken,
  input  logic [31:0]      btb_target,
  output logic [31:0]      pc,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic             id_pred_taken,
  output logic [31:0]      id_pred_target,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] pred_taken_cnt
);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;
  logic            id_valid_reg;
  logic [PC_W-1:0] id_pc_reg;
  logic            id_pred_taken_reg;
  logic [PC_W-1:0] id_pred_target_reg;

  logic            pred_hit;
  logic            advance;
  logic            held;
  logic [PC_W-1:0] target_aligned;

  assign pred_hit       = btb_valid & btb_taken;
  assign held           = stall | ~imem_ready;
  assign advance        = ~stall & imem_ready & ~redirect;
  assign target_aligned = align(btb_target);

  // Next-PC select; redirect beats a stall so EX corrections are never lost.
  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = align(redirect_pc);
    end else if (held) begin
      pc_next = pc_reg;
    end else if (pred_hit) begin
      pc_next = target_aligned;
    end else begin
      pc_next = pc_reg + PC_STEP;
    end
  end

  // Fetch PC register; pc is a pure register output so BTB lookups see no loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= align(RESET_PC);
    end else begin
      pc_reg <= pc_next;
    end
  end

  // IF/ID boundary: squash on redirect, freeze on stall, bubble when imem is busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_reg       <= 1'b0;
      id_pc_reg          <= '0;
      id_pred_taken_reg  <= 1'b0;
      id_pred_target_reg <= '0;
    end else if (redirect) begin
      id_valid_reg <= 1'b0;
    end else if (stall) begin
      id_valid_reg <= id_valid_reg;
    end else if (!imem_ready) begin
      id_valid_reg <= 1'b0;
    end else begin
      id_valid_reg       <= 1'b1;
      id_pc_reg          <= pc_reg;
      id_pred_taken_reg  <= pred_hit;
      id_pred_target_reg <= pred_hit ? target_aligned : '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_pred_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (advance & pred_hit),
    .count (pred_taken_cnt)
  );

  assign pc             = pc_reg;
  assign id_valid       = id_valid_reg;
  assign id_pc          = id_pc_reg;
  assign id_pred_taken  = id_pred_taken_reg;
  assign id_pred_target = id_pred_target_reg;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios then random traffic against a reference model.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        imem_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        btb_valid;
  logic        btb_taken;
  logic [31:0] btb_target;

  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic [15:0] redirect_cnt;
  logic [15:0] pred_taken_cnt;

  // Narrow-counter copy to reach saturation quickly.
  logic [31:0] s_pc;
  logic        s_id_valid;
  logic [31:0] s_id_pc;
  logic        s_id_pred_taken;
  logic [31:0] s_id_pred_target;
  logic [1:0]  s_redirect_cnt;
  logic [1:0]  s_pred_taken_cnt;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Reference model state (counters unbounded, clamped when compared).
  longint      m_pc;
  bit          m_idv;
  longint      m_idpc;
  bit          m_idpt;
  longint      m_idtgt;
  int          m_rc;
  int          m_ptc;

  fetch_pc_gen #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .btb_valid(btb_valid), .btb_taken(btb_taken), .btb_target(btb_target),
    .pc(pc), .id_valid(id_valid), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .id_pred_target(id_pred_target), .redirect_cnt(redirect_cnt),
    .pred_taken_cnt(pred_taken_cnt)
  );

  fetch_pc_gen #(.RESET_PC(32'h0), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .btb_valid(btb_valid), .btb_taken(btb_taken), .btb_target(btb_target),
    .pc(s_pc), .id_valid(s_id_valid), .id_pc(s_id_pc), .id_pred_taken(s_id_pred_taken),
    .id_pred_target(s_id_pred_target), .redirect_cnt(s_redirect_cnt),
    .pred_taken_cnt(s_pred_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint word_of(input longint a);
    return (a / 4) * 4;
  endfunction

  function automatic longint sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // One clock edge of the architectural behaviour, from the rules in plain arithmetic.
  task automatic model_edge();
    bit hit;
    hit = btb_valid && btb_taken;
    if (rst) begin
      m_pc = 0; m_idv = 0; m_idpc = 0; m_idpt = 0; m_idtgt = 0; m_rc = 0; m_ptc = 0;
    end else if (redirect) begin
      m_pc  = word_of(redirect_pc);
      m_idv = 0;
      m_rc  = m_rc + 1;
    end else if (stall) begin
      // everything frozen
    end else if (!imem_ready) begin
      m_idv = 0;
    end else begin
      m_idv   = 1;
      m_idpc  = m_pc;
      m_idpt  = hit;
      m_idtgt = hit ? word_of(btb_target) : 0;
      m_pc    = hit ? word_of(btb_target) : (m_pc + 4) % 64'h1_0000_0000;
      if (hit) m_ptc = m_ptc + 1;
    end
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s step=%0d got=%h exp=%h", tag, step_no, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("id_valid", id_valid, m_idv);
    chk("id_pc", id_pc, m_idpc);
    chk("id_pred_taken", id_pred_taken, m_idpt);
    chk("id_pred_target", id_pred_target, m_idtgt);
    chk("redirect_cnt", redirect_cnt, sat(m_rc, 65535));
    chk("pred_taken_cnt", pred_taken_cnt, sat(m_ptc, 65535));
    chk("small_pc", s_pc, m_pc);
    chk("small_redirect_cnt", s_redirect_cnt, sat(m_rc, 3));
    chk("small_pred_taken_cnt", s_pred_taken_cnt, sat(m_ptc, 3));
  endtask

  // Apply the current inputs across one edge, then compare just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    step_no++;
    check_all();
    $display("step %0d rst=%0b stl=%0b rdy=%0b rd=%0b hit=%0b pc=%h id_v=%0b id_pc=%h rc=%0d ptc=%0d",
             step_no, rst, stall, imem_ready, redirect, btb_valid & btb_taken,
             pc, id_valid, id_pc, redirect_cnt, pred_taken_cnt);
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; imem_ready = 1; redirect = 0; redirect_pc = 0;
    btb_valid = 0; btb_taken = 0; btb_target = 0;
  endtask

  initial begin
    m_pc = 0; m_idv = 0; m_idpc = 0; m_idpt = 0; m_idtgt = 0; m_rc = 0; m_ptc = 0;
    idle_inputs();
    rst = 1; stall = 1; redirect = 1; redirect_pc = 32'h500;
    step();
    // explicit reset-state check in addition to the model compare
    chk("reset_pc", pc, 0);
    chk("reset_id_valid", id_valid, 0);

    // Sequential fetch 0,4,8 then a taken hit at 8 to 0x40.
    idle_inputs();
    step(); step();
    chk("seq_pc_8", pc, 32'h8);
    btb_valid = 1; btb_taken = 1; btb_target = 32'h40;
    step();
    chk("hit_pc", pc, 32'h40);
    chk("hit_id_tgt", id_pred_target, 32'h40);
    // Valid but not taken -> sequential.
    btb_taken = 0;
    step();
    chk("nt_pc", pc, 32'h44);
    // Taken with misaligned target -> low bits cleared.
    btb_taken = 1; btb_target = 32'h43;
    step();
    chk("misalign_pc", pc, 32'h40);

    // Redirect during stall, then release.
    idle_inputs();
    stall = 1; redirect = 1; redirect_pc = 32'h100;
    step();
    chk("redir_pc", pc, 32'h100);
    redirect = 0;
    step();
    stall = 0;
    step();
    chk("redir_id_pc", id_pc, 32'h100);

    // imem not ready for 3 cycles at 0x20.
    redirect = 1; redirect_pc = 32'h20;
    step();
    redirect = 0; imem_ready = 0;
    repeat (3) step();
    chk("hold_pc", pc, 32'h20);
    imem_ready = 1;
    step();
    chk("ready_id_pc", id_pc, 32'h20);

    // Wrap at the top of the address space.
    redirect = 1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 0;
    step();
    chk("wrap_pc", pc, 0);

    // Back-to-back redirects: last wins, each counted (narrow counter saturates).
    for (int i = 0; i < 5; i++) begin
      redirect = 1; redirect_pc = 32'h200 + 32'(i * 16);
      step();
    end
    redirect = 0;
    chk("small_rc_sat", s_redirect_cnt, 3);

    // Reset mid-stream with stall and redirect active.
    rst = 1; stall = 1; redirect = 1;
    step();
    idle_inputs();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      imem_ready  = ($urandom_range(0, 4) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      btb_valid   = $urandom_range(0, 1);
      btb_taken   = $urandom_range(0, 1);
      btb_target  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
